// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, centre serve spot, ball FSM
// encoding and the score wrap helper.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SERVE_X  = 316;
  localparam int SERVE_Y  = 236;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } ball_state_t;

  // Scores are shown as a single digit, so nine rolls over to zero.
  function automatic logic [3:0] score_inc(input logic [3:0] score);
    return (score == 4'd9) ? 4'd0 : score + 4'd1;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector for the vertical blanking level. It produces a
// one-cycle tick that paces all ball motion. After reset, a low level
// must be seen before any edge counts. This keeps a level that is already
// high at reset release from being mistaken for a new frame.
module frame_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic tick
);

  logic level_q;
  logic armed;

  // Keep last cycle's level and note once the level has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (!level) begin
        armed <= 1'b1;
      end
    end
  end

  assign tick = level & ~level_q & armed;

endmodule

// File: rtl/ball_motion.sv
// Pong ball physics and game flow. The ball waits at the centre until it
// is served. It then moves once per frame, bouncing off walls and paddles.
// When it leaves the court, the other player scores. The ball then rests
// for a pause before returning to the centre, aimed at the player who lost
// the point.
module ball_motion
  import pong_pkg::*;
#(
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int SPEED        = 2,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       endofframe,
  input  logic       serve,
  input  logic [9:0] paddle_one_y,
  input  logic [9:0] paddle_two_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       point_scored
);

  // All position maths is done 11 bits wide so sums and differences near
  // the screen edges never wrap before they are compared.
  localparam logic [10:0] SPD        = 11'(SPEED);
  localparam logic [10:0] BSZ        = 11'(BALL_SIZE);
  localparam logic [10:0] PH         = 11'(PADDLE_H);
  localparam logic [10:0] P1_EDGE    = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] P2_EDGE    = 11'(P2_X - BALL_SIZE);
  localparam logic [10:0] RIGHT_LIM  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] BOTTOM_LIM = 11'(SCREEN_H - BALL_SIZE);

  localparam int PCW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [PCW-1:0] PAUSE_LAST = PCW'(PAUSE_FRAMES - 1);

  ball_state_t    state;
  logic           dx;
  logic           dy;
  logic [PCW-1:0] pause_cnt;
  logic           tick;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] p1_ext;
  logic [10:0] p2_ext;
  logic        overlap_one;
  logic        overlap_two;

  logic [9:0]  next_x;
  logic [9:0]  next_y;
  logic        next_dx;
  logic        next_dy;
  logic        miss_left;
  logic        miss_right;

  frame_tick u_frame_tick (
    .clk   (clk50M),
    .rst_n (reset),
    .level (endofframe),
    .tick  (tick)
  );

  assign x_ext  = {1'b0, ball_x};
  assign y_ext  = {1'b0, ball_y};
  assign p1_ext = {1'b0, paddle_one_y};
  assign p2_ext = {1'b0, paddle_two_y};

  // The ball and a paddle share some rows, which makes a paddle contact possible.
  assign overlap_one = (y_ext + BSZ > p1_ext) && (y_ext < p1_ext + PH);
  assign overlap_two = (y_ext + BSZ > p2_ext) && (y_ext < p2_ext + PH);

  // Work out the candidate next position. The vertical and horizontal
  // rules are independent, so a wall bounce and a paddle bounce can
  // happen in the same frame.
  always_comb begin
    next_x     = ball_x;
    next_y     = ball_y;
    next_dx    = dx;
    next_dy    = dy;
    miss_left  = 1'b0;
    miss_right = 1'b0;

    if (!dy) begin
      if (y_ext < SPD) begin
        next_y  = '0;
        next_dy = 1'b1;
      end else begin
        next_y = 10'(y_ext - SPD);
      end
    end else begin
      if (y_ext + SPD > BOTTOM_LIM) begin
        next_y  = 10'(BOTTOM_LIM);
        next_dy = 1'b0;
      end else begin
        next_y = 10'(y_ext + SPD);
      end
    end

    if (!dx) begin
      if ((x_ext >= P1_EDGE) && (x_ext - SPD < P1_EDGE) && overlap_one) begin
        next_x  = 10'(P1_EDGE);
        next_dx = 1'b1;
      end else if (x_ext < SPD) begin
        miss_left = 1'b1;
      end else begin
        next_x = 10'(x_ext - SPD);
      end
    end else begin
      if ((x_ext <= P2_EDGE) && (x_ext + SPD > P2_EDGE) && overlap_two) begin
        next_x  = 10'(P2_EDGE);
        next_dx = 1'b0;
      end else if (x_ext + SPD > RIGHT_LIM) begin
        miss_right = 1'b1;
      end else begin
        next_x = 10'(x_ext + SPD);
      end
    end
  end

  // Game flow: wait for a serve, move once per frame, then score and pause.
  // On a miss the direction bit is left alone because it already points at
  // the player who conceded, which is where the next serve must go.
  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      state        <= SERVE;
      ball_x       <= 10'(SERVE_X);
      ball_y       <= 10'(SERVE_Y);
      dx           <= 1'b1;
      dy           <= 1'b1;
      score_one    <= '0;
      score_two    <= '0;
      pause_cnt    <= '0;
      point_scored <= 1'b0;
    end else begin
      point_scored <= 1'b0;
      case (state)
        SERVE: begin
          ball_x <= 10'(SERVE_X);
          ball_y <= 10'(SERVE_Y);
          if (tick && serve) begin
            state <= PLAY;
          end
        end

        PLAY: begin
          if (tick) begin
            if (miss_left || miss_right) begin
              state        <= SCORED;
              pause_cnt    <= '0;
              point_scored <= 1'b1;
              if (miss_left) begin
                score_two <= score_inc(score_two);
              end else begin
                score_one <= score_inc(score_one);
              end
            end else begin
              ball_x <= next_x;
              ball_y <= next_y;
              dx     <= next_dx;
              dy     <= next_dy;
            end
          end
        end

        SCORED: begin
          if (tick) begin
            if (pause_cnt == PAUSE_LAST) begin
              state     <= SERVE;
              pause_cnt <= '0;
              ball_x    <= 10'(SERVE_X);
              ball_y    <= 10'(SERVE_Y);
              dy        <= 1'b1;
            end else begin
              pause_cnt <= pause_cnt + PCW'(1);
            end
          end
        end

        default: begin
          state <= SERVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion. It plays one long rally through both
// walls and both paddles. It then runs misses on each side, including the
// score roll-over, and finishes with a reset in the middle of play.
module tb_ball_motion;

  logic       clk50M = 1'b0;
  logic       reset = 1'b0;
  logic       endofframe = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] paddle_one_y = 10'd150;
  logic [9:0] paddle_two_y = 10'd400;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_one;
  logic [3:0] score_two;
  logic       point_scored;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int pulse_base = 0;

  ball_motion dut (
    .clk50M       (clk50M),
    .reset        (reset),
    .endofframe   (endofframe),
    .serve        (serve),
    .paddle_one_y (paddle_one_y),
    .paddle_two_y (paddle_two_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .score_one    (score_one),
    .score_two    (score_two),
    .point_scored (point_scored)
  );

  // Generate the 50 MHz clock.
  always #10 clk50M = ~clk50M;

  // Count how many cycles point_scored is high.
  always @(negedge clk50M) begin
    if (point_scored === 1'b1) begin
      pulse_cnt++;
    end
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Check both ball coordinates.
  task automatic checkBall(input string tag, input int x, input int y);
    checkOutput({tag, ".x"}, 32'(ball_x), 32'(x));
    checkOutput({tag, ".y"}, 32'(ball_y), 32'(y));
  endtask

  // Apply n frame ticks. Each tick is two cycles high and two cycles low.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      endofframe = 1'b1;
      repeat (2) @(posedge clk50M);
      #1;
      endofframe = 1'b0;
      repeat (2) @(posedge clk50M);
      #1;
    end
  endtask

  // Apply one tick and check that exactly one point_scored cycle appears.
  task automatic scoreTick(input string tag);
    pulse_base = pulse_cnt;
    applyStimulus(1);
    checkOutput({tag, ".pulse"}, 32'(pulse_cnt - pulse_base), 32'd1);
  endtask

  initial begin
    $display("[TB] ball_motion directed bench");

    repeat (3) @(posedge clk50M);
    #1;
    checkBall("reset", 316, 236);
    checkOutput("reset.score_one", 32'(score_one), 32'd0);
    checkOutput("reset.score_two", 32'(score_two), 32'd0);
    checkOutput("reset.point", 32'(point_scored), 32'd0);

    reset = 1'b1;
    repeat (2) @(posedge clk50M);
    #1;

    // The serve tick only starts play; ten further ticks move the ball.
    serve = 1'b1;
    applyStimulus(1);
    serve = 1'b0;
    checkBall("serve", 316, 236);
    applyStimulus(10);
    checkBall("ten_ticks", 336, 256);

    // Bottom wall: the ball clamps to 472, holds for one frame, then rises.
    applyStimulus(107);
    checkBall("near_bottom", 550, 470);
    applyStimulus(1);
    checkBall("at_bottom", 552, 472);
    applyStimulus(1);
    checkBall("bottom_bounce", 554, 472);
    applyStimulus(1);
    checkBall("rising", 556, 470);

    // Paddle two at row 400 covers the ball at row 418.
    applyStimulus(26);
    checkBall("p2_reach", 608, 418);
    applyStimulus(1);
    checkBall("p2_hit", 608, 416);
    applyStimulus(1);
    checkBall("p2_after", 606, 414);

    // Top wall.
    applyStimulus(207);
    checkBall("at_top", 192, 0);
    applyStimulus(1);
    checkBall("top_bounce", 190, 0);
    applyStimulus(1);
    checkBall("falling", 188, 2);

    // Paddle one at row 150 covers the ball at row 166.
    applyStimulus(82);
    checkBall("p1_reach", 24, 166);
    applyStimulus(1);
    checkBall("p1_hit", 24, 168);
    applyStimulus(1);
    checkBall("p1_after", 26, 170);

    // Paddle two no longer lines up (ball at row 194), so player one scores.
    applyStimulus(291);
    checkBall("p2_pass", 608, 194);
    applyStimulus(12);
    checkBall("right_edge", 632, 170);
    scoreTick("miss_right");
    checkOutput("miss_right.score_one", 32'(score_one), 32'd1);
    checkOutput("miss_right.score_two", 32'(score_two), 32'd0);
    checkBall("miss_right.frozen", 632, 170);

    // Hold serve high through the pause. It must be ignored until the ball is back.
    serve = 1'b1;
    applyStimulus(59);
    checkBall("pause_59", 632, 170);
    applyStimulus(1);
    checkBall("pause_done", 316, 236);
    applyStimulus(1);
    checkBall("reserve", 316, 236);
    serve = 1'b0;
    applyStimulus(1);
    checkBall("serve_right", 318, 238);

    // Paddle two moves out of the way. Player one scores repeatedly until
    // the score wraps.
    paddle_two_y = 10'd0;
    applyStimulus(157);
    scoreTick("rally2");
    checkOutput("rally2.score_one", 32'(score_one), 32'd2);
    checkBall("rally2.frozen", 632, 394);
    for (int s = 3; s <= 10; s++) begin
      applyStimulus(60);
      checkBall($sformatf("rally%0d.centre", s), 316, 236);
      serve = 1'b1;
      applyStimulus(1);
      serve = 1'b0;
      applyStimulus(158);
      scoreTick($sformatf("rally%0d", s));
      checkOutput($sformatf("rally%0d.score_one", s), 32'(score_one), 32'(s % 10));
      checkBall($sformatf("rally%0d.frozen", s), 632, 394);
    end

    // Bounce off paddle two, then miss paddle one. Player two scores.
    paddle_two_y = 10'd400;
    paddle_one_y = 10'd300;
    applyStimulus(60);
    serve = 1'b1;
    applyStimulus(1);
    serve = 1'b0;
    applyStimulus(146);
    checkBall("left_rally.p2_reach", 608, 418);
    applyStimulus(1);
    checkBall("left_rally.p2_hit", 608, 416);
    applyStimulus(293);
    checkBall("p1_pass", 22, 168);
    applyStimulus(11);
    checkBall("left_edge", 0, 190);
    scoreTick("miss_left");
    checkOutput("miss_left.score_two", 32'(score_two), 32'd1);
    checkOutput("miss_left.score_one", 32'(score_one), 32'd0);
    checkBall("miss_left.frozen", 0, 190);
    applyStimulus(59);
    checkBall("left_pause_59", 0, 190);
    applyStimulus(1);
    checkBall("left_pause_done", 316, 236);
    serve = 1'b1;
    applyStimulus(1);
    serve = 1'b0;
    applyStimulus(1);
    checkBall("serve_left", 314, 238);

    // Reset during play takes effect at once. A high endofframe held across
    // release must not produce a tick.
    applyStimulus(5);
    checkBall("pre_reset", 304, 248);
    @(posedge clk50M);
    #1;
    reset = 1'b0;
    #1;
    checkBall("mid_reset", 316, 236);
    checkOutput("mid_reset.score_two", 32'(score_two), 32'd0);
    checkOutput("mid_reset.point", 32'(point_scored), 32'd0);
    serve = 1'b1;
    endofframe = 1'b1;
    repeat (2) @(posedge clk50M);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk50M);
    #1;
    endofframe = 1'b0;
    serve = 1'b0;
    repeat (2) @(posedge clk50M);
    #1;
    applyStimulus(1);
    checkBall("no_spurious_tick", 316, 236);
    serve = 1'b1;
    applyStimulus(1);
    serve = 1'b0;
    applyStimulus(1);
    checkBall("after_reset_play", 318, 238);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
